sfq_pulse_receiver: RTL and testbench



---
 rtl/sfq_rx_pkg.sv | 21 ++
 rtl/sfq_rx_fifo2.sv | 65 ++++++
 rtl/sfq_pulse_receiver.sv | 126 ++++++++++++
 tb/tb_sfq_pulse_receiver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sfq_rx_pkg.sv
// Shared types, default constants and counter-width helper for the SFQ pulse receiver.
package sfq_rx_pkg;

  localparam int SYNC_STAGES_DEF  = 2;
  localparam int BEGIN_CYCLES_DEF = 8;
  localparam int MIN_GAP_DEF      = 2;
  localparam int WINDOW_DEF       = 16;
  localparam int CNT_W_DEF        = 8;

  // Window result at the default count width; the top re-declares it at its own CNT_W.
  typedef struct packed {
    logic                 sat;
    logic [CNT_W_DEF-1:0] count;
  } sfq_res_t;

  // Bits needed to hold n distinct counter values (never less than one).
  function automatic int ctr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sfq_rx_fifo2.sv
// Two-entry in-order valid/ready FIFO; a push while full is accepted only alongside a pop.
// No bypass: a push into an empty FIFO becomes visible on the following cycle.
module sfq_rx_fifo2 #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  T     in_dat,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_dat,
  output logic full
);

  T           slot0_q, slot0_d;
  T           slot1_q, slot1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop, push;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    pop     = (cnt_q != 2'd0) && out_rdy;
    push    = in_vld && ((cnt_q != 2'd2) || pop);
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = in_dat;
        else               slot1_d = in_dat;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = in_dat;
        end else begin
          slot0_d = slot1_q;
          slot1_d = in_dat;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = slot0_q;
  assign full    = (cnt_q == 2'd2);

endmodule

// File: rtl/sfq_pulse_receiver.sv
// Toggle-encoded SFQ line receiver: synchronise, strobe each transition, flag close spacing,
// and deliver saturating per-window pulse counts through a 2-entry valid/ready buffer.
module sfq_pulse_receiver
  import sfq_rx_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter int BEGIN_CYCLES = BEGIN_CYCLES_DEF,
  parameter int MIN_GAP      = MIN_GAP_DEF,
  parameter int WINDOW       = WINDOW_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  output logic             q_pulse,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             drop,
  output logic             err_gap,
  input  logic             err_clr
);

  localparam int BLANK_W = ctr_w(BEGIN_CYCLES + 1);
  localparam int GAP_W   = ctr_w(MIN_GAP + 1);
  localparam int WIN_W   = ctr_w(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic             sat;
    logic [CNT_W-1:0] count;
  } res_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   a_prev_q, a_prev_d;
  logic [BLANK_W-1:0]     blank_q, blank_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [WIN_W-1:0]       win_q, win_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic                   q_pulse_q, q_pulse_d;
  logic                   err_gap_q, err_gap_d;
  logic                   drop_q, drop_d;

  logic blanking, trans, viol, win_close, acc_full, fifo_full;
  logic [CNT_W-1:0] acc_next;
  logic             sat_next;
  res_t             res, head;

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], a};
    a_prev_d  = sync_q[SYNC_STAGES-1];
    blanking  = (blank_q != '0);
    blank_d   = blanking ? blank_q - 1'b1 : blank_q;
    trans     = (sync_q[SYNC_STAGES-1] ^ a_prev_q) && !blanking;
    q_pulse_d = trans;

    // gap_q counts idle cycles since the last transition, so spacing = gap_q + 1.
    viol      = trans && ((int'(gap_q) + 1) < MIN_GAP);
    err_gap_d = viol || (err_gap_q && !err_clr);
    if (blanking)                        gap_d = GAP_W'(MIN_GAP);
    else if (trans)                      gap_d = '0;
    else if (gap_q == GAP_W'(MIN_GAP))   gap_d = gap_q;
    else                                 gap_d = gap_q + 1'b1;

    win_close = !blanking && (win_q == WIN_W'(WINDOW - 1));
    if (blanking || win_close) win_d = '0;
    else                       win_d = win_q + 1'b1;

    // The closing cycle's own transition is folded into the result it closes.
    acc_full  = (acc_q == CNT_MAX);
    acc_next  = (trans && !acc_full) ? acc_q + 1'b1 : acc_q;
    sat_next  = sat_q || (trans && acc_full);
    res.count = acc_next;
    res.sat   = sat_next;
    acc_d     = win_close ? '0 : acc_next;
    sat_d     = win_close ? 1'b0 : sat_next;

    drop_d    = win_close && fifo_full && !cnt_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      a_prev_q  <= 1'b0;
      blank_q   <= BLANK_W'(BEGIN_CYCLES);
      gap_q     <= GAP_W'(MIN_GAP);
      win_q     <= '0;
      acc_q     <= '0;
      sat_q     <= 1'b0;
      q_pulse_q <= 1'b0;
      err_gap_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      a_prev_q  <= a_prev_d;
      blank_q   <= blank_d;
      gap_q     <= gap_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      sat_q     <= sat_d;
      q_pulse_q <= q_pulse_d;
      err_gap_q <= err_gap_d;
      drop_q    <= drop_d;
    end
  end

  sfq_rx_fifo2 #(.T(res_t)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (win_close),
    .in_dat  (res),
    .out_vld (cnt_valid),
    .out_rdy (cnt_ready),
    .out_dat (head),
    .full    (fifo_full)
  );

  assign q_pulse  = q_pulse_q;
  assign err_gap  = err_gap_q;
  assign drop     = drop_q;
  assign cnt_data = head.count;
  assign cnt_sat  = head.sat;

endmodule

// File: tb/tb_sfq_pulse_receiver.sv
// Directed and randomized phases, each starting from reset, checked against a window/queue model.
module tb_sfq_pulse_receiver;

  localparam int S    = 2;
  localparam int BEG  = 8;
  localparam int MG   = 2;
  localparam int W    = 16;
  localparam int CW   = 8;
  localparam int W2   = 32;
  localparam int MAX2 = 15;
  localparam int MAXN = 256;
  localparam int MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a = 1'b0;
  logic cnt_ready = 1'b0;
  logic err_clr = 1'b0;

  logic          q_pulse, cnt_sat, cnt_valid, drop, err_gap;
  logic [CW-1:0] cnt_data;
  logic          q_pulse2, cnt_sat2, cnt_valid2, drop2, err_gap2;
  logic [3:0]    cnt_data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit tog [MAXN];
  bit rdy [MAXN];
  bit clr [MAXN];

  always #5 clk = ~clk;

  sfq_pulse_receiver dut (
    .clk(clk), .rst(rst), .a(a), .q_pulse(q_pulse), .cnt_data(cnt_data),
    .cnt_sat(cnt_sat), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
    .drop(drop), .err_gap(err_gap), .err_clr(err_clr)
  );

  sfq_pulse_receiver #(.CNT_W(4), .WINDOW(W2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .q_pulse(q_pulse2), .cnt_data(cnt_data2),
    .cnt_sat(cnt_sat2), .cnt_valid(cnt_valid2), .cnt_ready(cnt_ready),
    .drop(drop2), .err_gap(err_gap2), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // A toggle driven during cycle c0 is seen as a transition in cycle c0+S; it counts after blanking.
  function automatic bit counted(input int c);
    return (c >= BEG) && (c >= S) && tog[c - S];
  endfunction

  function automatic int win_cnt(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (counted(i)) n++;
    return n;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      tog[i] = 1'b0;
      rdy[i] = 1'b0;
      clr[i] = 1'b0;
    end
  endtask

  task automatic run_phase(input int n, input bit sat_ph);
    int q[$];
    int acc, last, n2, res;
    bit errm, drop_m, viol;
    acc = 0; last = -100; errm = 1'b0; drop_m = 1'b0;
    rst = 1'b1; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < n; c++) begin
      cyc = c;
      if (tog[c]) a = ~a;
      cnt_ready = rdy[c];
      err_clr = clr[c];
      @(negedge clk);
      chk("q_pulse", q_pulse, (c > 0) && counted(c - 1));
      chk("cnt_valid", cnt_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("cnt_data", cnt_data, q[0] % (1 << CW));
        chk("cnt_sat", cnt_sat, q[0] >> CW);
      end else if (c == 0) begin
        chk("rst_cnt_data", cnt_data, 0);
        chk("rst_cnt_sat", cnt_sat, 0);
      end
      chk("drop", drop, drop_m);
      chk("err_gap", err_gap, errm);
      if (sat_ph && (c == BEG + W2 || c == BEG + 2 * W2)) begin
        n2 = win_cnt(c - W2, c - 1);
        chk("sat_valid", cnt_valid2, 1);
        chk("sat_data", cnt_data2, (n2 > MAX2) ? MAX2 : n2);
        chk("sat_flag", cnt_sat2, n2 > MAX2);
      end
      // Model state as it stands at the end of cycle c.
      drop_m = 1'b0;
      viol = counted(c) && (c - last < MG);
      errm = viol || (errm && !clr[c]);
      if (counted(c)) begin
        last = c;
        acc++;
      end
      if (q.size() > 0 && rdy[c]) void'(q.pop_front());
      if (c >= BEG && (c - BEG) % W == W - 1) begin
        res = (acc > MAXV) ? ((1 << CW) | MAXV) : acc;
        if (q.size() < 2) q.push_back(res);
        else drop_m = 1'b1;
        acc = 0;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Blanking: early toggles vanish, first result is an empty window.
    clear_stim();
    tog[3] = 1; tog[5] = 1;
    run_phase(30, 0);

    // Counting and strobe latency: five toggles landing in window 1, last on its closing cycle.
    clear_stim();
    for (int i = 0; i < 5; i++) tog[25 + 3 * i] = 1;
    for (int i = 0; i < MAXN; i++) rdy[i] = 1;
    run_phase(45, 0);

    // Gap violation, clear, then clear coincident with a fresh violation.
    clear_stim();
    tog[10] = 1; tog[11] = 1;
    clr[20] = 1;
    tog[28] = 1; tog[29] = 1;
    clr[31] = 1;
    for (int i = 0; i < MAXN; i++) rdy[i] = 1;
    run_phase(40, 0);

    // Saturation on the narrow instance, then a fresh window starting from zero.
    clear_stim();
    for (int i = 8; i < 28; i++) tog[i] = 1;
    tog[50] = 1; tog[55] = 1; tog[60] = 1;
    rdy[BEG + W2] = 1;
    run_phase(75, 1);

    // Backpressure across three closes with counts 2, 3, 4, then drain.
    clear_stim();
    tog[8] = 1; tog[12] = 1;
    tog[24] = 1; tog[28] = 1; tog[32] = 1;
    tog[40] = 1; tog[44] = 1; tog[48] = 1; tog[52] = 1;
    for (int i = 60; i < 70; i++) rdy[i] = 1;
    run_phase(70, 0);

    // One buffered entry and pulses in flight when reset hits.
    clear_stim();
    tog[8] = 1; tog[26] = 1; tog[30] = 1; tog[34] = 1; tog[38] = 1;
    run_phase(40, 0);

    // After the mid-operation reset only post-blanking pulses count.
    clear_stim();
    tog[12] = 1;
    for (int i = 0; i < MAXN; i++) rdy[i] = 1;
    run_phase(30, 0);

    for (int p = 0; p < 5; p++) begin
      clear_stim();
      for (int i = 0; i < 114; i++) begin
        tog[i] = ($urandom_range(0, 3) == 0);
        rdy[i] = ($urandom_range(0, 1) == 1);
        clr[i] = ($urandom_range(0, 15) == 0);
      end
      run_phase(120, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
